// File: rtl/clap_sequence_decoder.sv
// clap_sequence_decoder: groups clap pulses into sequences split by silence
// and reports each finished sequence's clap count as a one-cycle command.
module clap_sequence_decoder #(
   parameter int GAP_TIMEOUT = 60_000_000,
   parameter int MAX_CLAPS   = 7
) (
   input  logic       M_CLK,
   input  logic       rst_i,
   input  logic       clap_pulse_i,
   output logic       cmd_valid_o,
   output logic [2:0] cmd_count_o,
   output logic       cmd_ovf_o,
   output logic       toggle_o,
   output logic       busy_o
);

   localparam int TW = $clog2(GAP_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(GAP_TIMEOUT - 1);
   localparam logic [2:0] C_MAX = 3'(MAX_CLAPS);

   typedef enum logic [1:0] {
      IDLE,
      COUNTING,
      REPORT
   } state_t;

   state_t          state, state_n;
   logic [2:0]      count, count_n;
   logic [TW-1:0]   timer, timer_n;
   logic            ovf, ovf_n;
   logic            valid_n;
   logic [2:0]      cmd_count_n;
   logic            cmd_ovf_n;
   logic            toggle_n;
   logic            busy_n;

   // state, sequence bookkeeping and registered outputs
   always_ff @(posedge M_CLK or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         count       <= '0;
         timer       <= '0;
         ovf         <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_count_o <= '0;
         cmd_ovf_o   <= 1'b0;
         toggle_o    <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         timer       <= timer_n;
         ovf         <= ovf_n;
         cmd_valid_o <= valid_n;
         cmd_count_o <= cmd_count_n;
         cmd_ovf_o   <= cmd_ovf_n;
         toggle_o    <= toggle_n;
         busy_o      <= busy_n;
      end
   end

   // next-state: clap counting, silence timing and report generation
   always_comb begin
      state_n     = state;
      count_n     = count;
      timer_n     = timer;
      ovf_n       = ovf;
      valid_n     = 1'b0;
      cmd_count_n = cmd_count_o;
      cmd_ovf_n   = cmd_ovf_o;
      toggle_n    = toggle_o;

      unique case (state)
         IDLE, REPORT: begin
            if (clap_pulse_i) begin
               count_n = 3'd1;
               ovf_n   = 1'b0;
               timer_n = '0;
               state_n = COUNTING;
            end else begin
               state_n = IDLE;
            end
         end
         COUNTING: begin
            if (clap_pulse_i) begin
               timer_n = '0;
               if (count < C_MAX) begin
                  count_n = count + 3'd1;
               end else begin
                  ovf_n = 1'b1;
               end
            end else if (timer == T_LAST) begin
               state_n     = REPORT;
               valid_n     = 1'b1;
               cmd_count_n = count;
               cmd_ovf_n   = ovf;
               if (count == 3'd2 && !ovf) begin
                  toggle_n = ~toggle_o;
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n == COUNTING);
   end

endmodule
